// File: rtl/regset_pkg.sv
// Shared defaults and the sweep/run state encoding for the scoreboarded register set.
package regset_pkg;
  localparam int WIDTH_DEF    = 32;
  localparam int DEPTH_DEF    = 32;
  localparam int NREAD_DEF    = 2;
  localparam int ZERO_REG_DEF = 1;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;
endpackage

// File: rtl/regset_scoreboard.sv
// Per-register busy bits: set by issue, cleared by write, issue wins on collision.
module regset_scoreboard
  import regset_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int NREAD = NREAD_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    CLK,
  input  logic                    RES,
  input  logic                    set_en,
  input  logic [ADDR_W-1:0]       set_addr,
  input  logic                    clr_en,
  input  logic [ADDR_W-1:0]       clr_addr,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD-1:0]        busy
);

  logic [DEPTH-1:0] busy_r;

  always_ff @(posedge CLK) begin
    if (RES) begin
      busy_r <= '0;
    end else begin
      if (clr_en) busy_r[clr_addr] <= 1'b0;
      // later assignment wins, so a new producer overrides a same-cycle write
      if (set_en) busy_r[set_addr] <= 1'b1;
    end
  end

  always_comb begin
    busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      busy[k] = busy_r[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/regset_sb.sv
// Register file with power-up clear sweep, same-cycle write bypass and busy scoreboard.
//   state    | meaning
//   ST_CLEAR | zeroing one register per cycle, file unusable, ready=0
//   ST_RUN   | normal reads/writes/issues, ready=1
module regset_sb
  import regset_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NREAD    = NREAD_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                    CLK,
  input  logic                    RES,
  input  logic [WIDTH-1:0]        D,
  input  logic [ADDR_W-1:0]       A_D,
  input  logic                    write_enable,
  input  logic [NREAD*ADDR_W-1:0] A_Q,
  output logic [NREAD*WIDTH-1:0]  Q,
  output logic [NREAD-1:0]        Q_busy,
  input  logic                    issue_en,
  input  logic [ADDR_W-1:0]       issue_addr,
  output logic                    ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_run;
  logic              iss_run;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [NREAD-1:0]  sb_busy;
  logic [ADDR_W-1:0] raddr;

  always_ff @(posedge CLK) begin
    if (RES) begin
      state     <= ST_CLEAR;
      sweep_cnt <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_ADDR) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // RES gates ready immediately so nothing leaks out during the reset cycle
  assign ready   = (state == ST_RUN) && !RES;
  assign wr_run  = ready && write_enable && !((ZERO_REG != 0) && (A_D == '0));
  assign iss_run = ready && issue_en && !((ZERO_REG != 0) && (issue_addr == '0));

  assign mem_we    = (state == ST_CLEAR) || wr_run;
  assign mem_waddr = (state == ST_CLEAR) ? sweep_cnt : A_D;
  assign mem_wdata = (state == ST_CLEAR) ? '0 : D;

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  regset_scoreboard #(
    .DEPTH(DEPTH),
    .NREAD(NREAD)
  ) u_scoreboard (
    .CLK     (CLK),
    .RES     (RES),
    .set_en  (iss_run),
    .set_addr(issue_addr),
    .clr_en  (wr_run),
    .clr_addr(A_D),
    .rd_addr (A_Q),
    .busy    (sb_busy)
  );

  always_comb begin
    Q      = '0;
    Q_busy = '0;
    raddr  = '0;
    for (int k = 0; k < NREAD; k++) begin
      raddr = A_Q[k*ADDR_W +: ADDR_W];
      if (ready && !((ZERO_REG != 0) && (raddr == '0))) begin
        Q[k*WIDTH +: WIDTH] = (wr_run && (A_D == raddr)) ? D : mem[raddr];
        Q_busy[k]           = sb_busy[k];
      end
    end
  end

endmodule

// File: tb/tb_regset_sb.sv
// Directed vector bench for regset_sb: default instance plus a small ZERO_REG=0 instance.
module tb_regset_sb;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        res, we, iss_en, rdy;
  logic [31:0] d;
  logic [4:0]  a_d, iss_addr;
  logic [9:0]  a_q;
  logic [63:0] q;
  logic [1:0]  q_busy;

  logic        res1, we1, iss1, rdy1;
  logic [15:0] d1;
  logic [2:0]  ad1, issa1;
  logic [8:0]  aq1;
  logic [47:0] q1;
  logic [2:0]  qb1;

  int n_cmp = 0;
  int n_err = 0;

  regset_sb u_dut (
    .CLK(CLK), .RES(res), .D(d), .A_D(a_d), .write_enable(we),
    .A_Q(a_q), .Q(q), .Q_busy(q_busy), .issue_en(iss_en),
    .issue_addr(iss_addr), .ready(rdy)
  );

  regset_sb #(.WIDTH(16), .DEPTH(8), .NREAD(3), .ZERO_REG(0)) u_dut_small (
    .CLK(CLK), .RES(res1), .D(d1), .A_D(ad1), .write_enable(we1),
    .A_Q(aq1), .Q(q1), .Q_busy(qb1), .issue_en(iss1),
    .issue_addr(issa1), .ready(rdy1)
  );

  typedef struct {
    logic        we;
    logic [4:0]  a_d;
    logic [31:0] d;
    logic        iss;
    logic [4:0]  iss_a;
    logic [4:0]  aq0;
    logic [4:0]  aq1;
    logic [31:0] eq0;
    logic [31:0] eq1;
    logic        eb0;
    logic        eb1;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    // we a_d d iss iss_a aq0 aq1 | eq0 eq1 eb0 eb1
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0,  5, 6,  32'hDEADBEEF, 32'h0,        0, 0};
    vecs[1]  = '{0, 0, 32'h0,        0, 0,  5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    vecs[2]  = '{0, 0, 32'h0,        1, 7,  7, 5,  32'h0,        32'hDEADBEEF, 0, 0};
    vecs[3]  = '{0, 0, 32'h0,        0, 0,  7, 0,  32'h0,        32'h0,        1, 0};
    vecs[4]  = '{1, 7, 32'h1,        0, 0,  7, 0,  32'h1,        32'h0,        1, 0};
    vecs[5]  = '{0, 0, 32'h0,        0, 0,  7, 0,  32'h1,        32'h0,        0, 0};
    vecs[6]  = '{1, 9, 32'hAAAA5555, 1, 9,  9, 7,  32'hAAAA5555, 32'h1,        0, 0};
    vecs[7]  = '{0, 0, 32'h0,        0, 0,  9, 7,  32'hAAAA5555, 32'h1,        1, 0};
    vecs[8]  = '{1, 0, 32'hFFFFFFFF, 1, 0,  0, 9,  32'h0,        32'hAAAA5555, 0, 1};
    vecs[9]  = '{0, 0, 32'h0,        0, 0,  0, 5,  32'h0,        32'hDEADBEEF, 0, 0};
    vecs[10] = '{1, 5, 32'hCAFEF00D, 0, 0,  5, 5,  32'hCAFEF00D, 32'hCAFEF00D, 0, 0};
    vecs[11] = '{1, 9, 32'h11,       1, 12, 9, 12, 32'h11,       32'h0,        1, 0};
    vecs[12] = '{0, 0, 32'h0,        0, 0,  9, 12, 32'h11,       32'h0,        0, 1};

    res = 1'b1; we = 1'b0; iss_en = 1'b0; d = '0; a_d = '0; iss_addr = '0; a_q = {5'd3, 5'd31};
    res1 = 1'b1; we1 = 1'b0; iss1 = 1'b0; d1 = '0; ad1 = '0; issa1 = '0; aq1 = '0;

    step();
    chk("rst_ready", {63'd0, rdy}, 64'd0);
    chk("rst_q", q, 64'd0);
    chk("rst_busy", {62'd0, q_busy}, 64'd0);
    res = 1'b0;

    for (int c = 0; c < 32; c++) begin
      #1;
      chk("sweep_ready", {63'd0, rdy}, 64'd0);
      chk("sweep_q", q, 64'd0);
      step();
    end
    #1;
    chk("ready_after_32", {63'd0, rdy}, 64'd1);

    for (int i = 0; i < 13; i++) begin
      we = vecs[i].we; a_d = vecs[i].a_d; d = vecs[i].d;
      iss_en = vecs[i].iss; iss_addr = vecs[i].iss_a;
      a_q = {vecs[i].aq1, vecs[i].aq0};
      #1;
      chk($sformatf("vec%0d_q0", i), {32'd0, q[31:0]}, {32'd0, vecs[i].eq0});
      chk($sformatf("vec%0d_q1", i), {32'd0, q[63:32]}, {32'd0, vecs[i].eq1});
      chk($sformatf("vec%0d_busy", i), {62'd0, q_busy}, {62'd0, vecs[i].eb1, vecs[i].eb0});
      step();
    end
    we = 1'b0; iss_en = 1'b0;

    // mid-sweep reset: populate, reset, reset again at sweep count 10
    we = 1'b1; a_d = 5'd3; d = 32'h12345678; iss_en = 1'b1; iss_addr = 5'd4;
    a_q = {5'd4, 5'd3};
    step();
    we = 1'b0; iss_en = 1'b0;
    #1;
    chk("pre_rst_reg3", {32'd0, q[31:0]}, 64'h12345678);
    chk("pre_rst_busy4", {62'd0, q_busy}, 64'd2);
    res = 1'b1;
    #1;
    chk("res_in_run_ready", {63'd0, rdy}, 64'd0);
    chk("res_in_run_q", q, 64'd0);
    chk("res_in_run_busy", {62'd0, q_busy}, 64'd0);
    step();
    res = 1'b0;
    repeat (10) step();
    res = 1'b1;
    #1;
    chk("mid_sweep_res_ready", {63'd0, rdy}, 64'd0);
    step();
    res = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (c == 20) begin
        we = 1'b1; a_d = 5'd3; d = 32'hFFFFFFFF; iss_en = 1'b1; iss_addr = 5'd3;
        a_q = {5'd3, 5'd3};
      end else begin
        we = 1'b0; iss_en = 1'b0; a_q = {5'd4, 5'd3};
      end
      #1;
      chk("resweep_ready", {63'd0, rdy}, 64'd0);
      chk("resweep_q", q, 64'd0);
      chk("resweep_busy", {62'd0, q_busy}, 64'd0);
      step();
    end
    we = 1'b0; iss_en = 1'b0; a_q = {5'd4, 5'd3};
    #1;
    chk("resweep_ready_after_32", {63'd0, rdy}, 64'd1);
    chk("resweep_reg3_zero", {32'd0, q[31:0]}, 64'd0);
    chk("resweep_busy_zero", {62'd0, q_busy}, 64'd0);
    a_q = {5'd9, 5'd3};
    #1;
    chk("resweep_reg9_zero", {32'd0, q[63:32]}, 64'd0);

    // small instance: WIDTH=16 DEPTH=8 NREAD=3 ZERO_REG=0
    res1 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("small_sweep_ready", {63'd0, rdy1}, 64'd0);
      step();
    end
    #1;
    chk("small_ready_after_8", {63'd0, rdy1}, 64'd1);
    we1 = 1'b1; ad1 = 3'd0; d1 = 16'h1234; aq1 = {3'd7, 3'd3, 3'd0};
    #1;
    chk("small_bypass_a0", {48'd0, q1[15:0]}, 64'h1234);
    step();
    ad1 = 3'd3; d1 = 16'hBEEF;
    step();
    ad1 = 3'd7; d1 = 16'h0F0F; iss1 = 1'b1; issa1 = 3'd0;
    step();
    we1 = 1'b0; iss1 = 1'b0;
    #1;
    chk("small_q_ports", {16'd0, q1}, {16'd0, 16'h0F0F, 16'hBEEF, 16'h1234});
    chk("small_busy_a0", {61'd0, qb1}, 64'd1);
    aq1 = {3'd0, 3'd7, 3'd3};
    #1;
    chk("small_q_permuted", {16'd0, q1}, {16'd0, 16'h1234, 16'h0F0F, 16'hBEEF});
    chk("small_busy_permuted", {61'd0, qb1}, 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regset_sb.md
REGSET_SB -- requirements
Module: regset_sb

Interface
REQ-001: The module SHALL have parameter WIDTH, default 32, data bits per register.
REQ-002: The module SHALL have parameter DEPTH, default 32, number of registers (power of two, >=2); ADDR_W = clog2(DEPTH).
REQ-003: The module SHALL have parameter NREAD, default 2, number of read ports (1..4).
REQ-004: The module SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-005: Port CLK  input  1  single clock; all state updates on rising edge.
REQ-006: Port RES  input  1  reset, synchronous, active-high.
REQ-007: Port D  input  WIDTH  write data.
REQ-008: Port A_D  input  ADDR_W  write address.
REQ-009: Port write_enable  input  1  write strobe.
REQ-010: Port A_Q  input  NREAD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-011: Port Q  output  NREAD*WIDTH  packed read data, same packing.
REQ-012: Port Q_busy  output  NREAD  scoreboard busy flag of each read port's address.
REQ-013: Port issue_en  input  1  mark a register as pending (producer in flight).
REQ-014: Port issue_addr  input  ADDR_W  register to mark pending.
REQ-015: Port ready  output  1  high when the clear sweep is complete and the file is usable.

Function
REQ-016: Two states, ST_CLEAR and ST_RUN; RES forces ST_CLEAR with sweep counter 0.
REQ-017: In ST_CLEAR one register per cycle SHALL be written to zero, address = counter, counter incrementing; after address DEPTH-1 is cleared the next state SHALL be ST_RUN (DEPTH cycles after RES deasserts).
REQ-018: ready SHALL be 0 in ST_CLEAR and 1 in ST_RUN.
REQ-019: In ST_CLEAR write_enable and issue_en SHALL be ignored and all Q SHALL read zero, all Q_busy zero.
REQ-020: In ST_RUN write_enable=1 SHALL store D at A_D on the clock edge.
REQ-021: Reads SHALL be combinational: Q[k] = register A_Q[k] with zero-latency bypass: if write_enable=1, ready=1 and A_D==A_Q[k] (and the write is not suppressed by REQ-024), Q[k] SHALL equal D in the same cycle.
REQ-022: Scoreboard: issue_en=1 in ST_RUN SHALL set busy[issue_addr] on the edge; a write to A_D SHALL clear busy[A_D] on the edge.
REQ-023: Same-cycle issue and write to the same address: busy SHALL end at 1 (new producer wins); data is still written.
REQ-024: ZERO_REG=1: address 0 SHALL read zero, never report busy, and writes/issues to address 0 SHALL be ignored (no bypass either).
REQ-025: Writes to a non-busy register SHALL be accepted (no error); Q_busy[k] SHALL reflect registered busy state, not bypassed by same-cycle issue/write.
REQ-026: All read ports SHALL be independent; multiple ports may address the same register.

Reset
REQ-027: RES=1 at any edge, including mid-sweep, SHALL restart the sweep at address 0 and clear all busy bits in parallel.
REQ-028: While RES=1, ready=0, all Q=0, all Q_busy=0.
REQ-029: No asynchronous reset SHALL exist; storage SHALL need no reset other than the sweep (block-RAM/LUTRAM friendly, one write port).

Structure
REQ-030: Package regset_pkg SHALL hold default parameter constants and the state enum (ST_CLEAR, ST_RUN).
REQ-031: One sub-module regset_scoreboard (DEPTH busy bits, set/clear/priority, NREAD lookup) SHALL be instantiated; storage, sweep FSM and bypass stay in regset_sb.

Verification
REQ-032: RES 1 cycle, then idle -> ready=0 for exactly 32 cycles, ready=1 on cycle 33; all Q=0 throughout.
REQ-033: ST_RUN, write_enable=1, A_D=5, D=32'hDEADBEEF, A_Q[0]=5 -> Q[0]=32'hDEADBEEF same cycle; next cycle with write_enable=0 still 32'hDEADBEEF.
REQ-034: issue_en=1, issue_addr=7 -> Q_busy for A_Q=7 rises next cycle; write A_D=7 D=1 -> busy falls next cycle; same-cycle issue+write to 9 -> busy[9]=1, data=written value.
REQ-035: ZERO_REG=1, write A_D=0 D=32'hFFFFFFFF, issue_addr=0 -> Q for address 0 stays 0, Q_busy 0, no bypass.
REQ-036: Write reg 3 = 32'h12345678, busy reg 4, assert RES at sweep count 10 of a second reset -> sweep restarts, ready after 32 further cycles, reg 3 reads 0, busy all 0.
REQ-037: Parameter sweep WIDTH=16, DEPTH=8, NREAD=3, ZERO_REG=0 -> address 0 writable, ready after 8 cycles, three ports read distinct registers correctly.
